// File: rtl/bp_stream_pkg.sv
// Shared types for the UART-to-stream host-link front end.
package bp_stream_pkg;

  typedef enum logic [1:0] {
    e_rx_idle,
    e_rx_start,
    e_rx_data,
    e_rx_stop
  } bp_uart_rx_state_e;

  function automatic int unsigned idx_width(int unsigned bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/bp_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit FSM and mid-bit baud counter.
module bp_uart_rx_byte
  import bp_stream_pkg::*;
#(
  parameter int unsigned clk_per_bit_p = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       byte_v_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(clk_per_bit_p);
  localparam logic [CntW-1:0] HalfEnd = CntW'(clk_per_bit_p / 2 - 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(clk_per_bit_p - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  bp_uart_rx_state_e state_q;
  logic [1:0]        sync_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              byte_v_q;
  logic              frame_err_q;
  logic              rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_rx_idle;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_v_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      byte_v_q    <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        e_rx_idle: begin
          if (!rx_s) begin
            state_q <= e_rx_start;
            cnt_q   <= '0;
          end
        end
        e_rx_start: begin
          // Re-check the start bit at its midpoint to reject glitches.
          if (cnt_q == HalfEnd) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? e_rx_idle : e_rx_data;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        e_rx_data: begin
          if (cnt_q == BitEnd) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= e_rx_stop;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        e_rx_stop: begin
          if (cnt_q == BitEnd) begin
            cnt_q       <= '0;
            state_q     <= e_rx_idle;
            byte_v_q    <= rx_s;
            frame_err_q <= ~rx_s;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= e_rx_idle;
      endcase
    end
  end

  assign byte_v_o    = byte_v_q;
  assign byte_o      = shift_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/bp_stream_uart_rx.sv
// UART receiver feeding the NBF loader: packs bytes little-endian into words behind a 2-entry buffer.
module bp_stream_uart_rx
  import bp_stream_pkg::*;
#(
  parameter int unsigned clk_per_bit_p       = 16,
  parameter int unsigned stream_data_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           rx_i,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  output logic                           framing_error_o,
  output logic                           overflow_o
);

  localparam int unsigned Bpw  = stream_data_width_p / 8;
  localparam int unsigned IdxW = idx_width(Bpw);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Bpw - 1);

  logic       byte_v;
  logic [7:0] byte_data;
  logic       frame_err;

  bp_uart_rx_byte #(
    .clk_per_bit_p(clk_per_bit_p)
  ) u_rx_byte (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_i       (rx_i),
    .byte_v_o   (byte_v),
    .byte_o     (byte_data),
    .frame_err_o(frame_err)
  );

  logic [IdxW-1:0]                idx_q, idx_d;
  logic [stream_data_width_p-1:0] word_q, word_d;
  logic                           enq;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    enq    = 1'b0;
    if (byte_v) begin
      word_d[8*int'(idx_q) +: 8] = byte_data;
      if (idx_q == IdxLast) begin
        idx_d = '0;
        enq   = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  logic [stream_data_width_p-1:0] mem_q [2];
  logic                           wptr_q, rptr_q;
  logic [1:0]                     cnt_q;
  logic                           full, empty, push, deq;
  logic                           framing_error_q, overflow_q;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  // Fullness is judged before any same-cycle dequeue, so a full buffer always drops.
  assign push  = enq & ~full;
  assign deq   = stream_ready_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q           <= '0;
      word_q          <= '0;
      wptr_q          <= 1'b0;
      rptr_q          <= 1'b0;
      cnt_q           <= 2'd0;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      if (push) wptr_q <= ~wptr_q;
      if (deq)  rptr_q <= ~rptr_q;
      unique case ({push, deq})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (enq && full) overflow_q <= 1'b1;
      if (frame_err)   framing_error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= word_d;
  end

  assign stream_v_o      = ~empty;
  assign stream_data_o   = mem_q[rptr_q];
  assign framing_error_o = framing_error_q;
  assign overflow_o      = overflow_q;

endmodule
